// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: one pixel width for the convolution,
// window-gather and max-pooling stages.
package cnn_pkg;

   localparam int DATA_W = 22;

   typedef logic signed [DATA_W-1:0] pixel_t;

   // Counter width for a dimension of n positions, never narrower than 1 bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pool_window_gather_if.sv
// Pixel-stream input and 2x2 window output bundle of the window gatherer.
interface pool_window_gather_if #(
   parameter int DATA_W = cnn_pkg::DATA_W
);
   // in_valid: in_data is consumed on every rising edge where it is high; there
   // is no ready, the source must never present a pixel the sink cannot take.
   // win_valid: one-cycle strobe, win_* and win_last are meaningful only then.
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] win_tl;
   logic [DATA_W-1:0] win_tr;
   logic [DATA_W-1:0] win_bl;
   logic [DATA_W-1:0] win_br;
   logic              win_valid;
   logic              win_last;
   logic              busy;

   modport master (
      output in_valid, in_data,
      input  win_tl, win_tr, win_bl, win_br, win_valid, win_last, busy
   );

   modport slave (
      input  in_valid, in_data,
      output win_tl, win_tr, win_bl, win_br, win_valid, win_last, busy
   );
endinterface

// File: rtl/pool_line_buffer.sv
// One feature-map row of storage: single write port, two asynchronous read
// ports so the top-left and top-right pixels are available together.
module pool_line_buffer #(
   parameter int DATA_W = 22,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pool_window_gather.sv
// Reassembles non-overlapping 2x2 windows from a raster pixel stream using a
// single line buffer; each window is presented for one cycle on win_valid.
module pool_window_gather
   import cnn_pkg::*;
#(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int IMG_W  = 4,
   parameter int IMG_H  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pool_window_gather_if.slave  bus
);

   localparam int COL_W = cnt_w(IMG_W);
   localparam int ROW_W = cnt_w(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   generate
      if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_w
         $error("pool_window_gather: IMG_W must be even and >= 2");
      end
      if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_h
         $error("pool_window_gather: IMG_H must be even and >= 2");
      end
   endgenerate

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col_left;
   logic [DATA_W-1:0] prev_px;
   logic [DATA_W-1:0] rd_left;
   logic [DATA_W-1:0] rd_right;
   logic [DATA_W-1:0] tl_q, tr_q, bl_q, br_q;
   logic              valid_q, last_q, busy_q;
   logic              accept, col_wrap, frame_end, lb_we, win_done;

   assign accept    = bus.in_valid;
   assign col_wrap  = (col == COL_LAST);
   assign frame_end = col_wrap && (row == ROW_LAST);
   assign lb_we     = accept && !row[0];
   assign win_done  = accept && row[0] && col[0];
   assign col_left  = col - COL_W'(1);

   // Even rows fill the buffer; odd rows only read it, and the odd row always
   // finishes reading a column pair before the next even row rewrites it.
   pool_line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .AW     (COL_W)
   ) u_line_buf (
      .clk     (clk),
      .we      (lb_we),
      .waddr   (col),
      .wdata   (bus.in_data),
      .raddr_a (col_left),
      .raddr_b (col),
      .rdata_a (rd_left),
      .rdata_b (rd_right)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         col <= col_wrap ? '0 : col + COL_W'(1);
         if (col_wrap) row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_px <= '0;
      end else if (accept && row[0] && !col[0]) begin
         prev_px <= bus.in_data;
      end
   end

   // Window registers hold between strobes; only valid/last are pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tl_q    <= '0;
         tr_q    <= '0;
         bl_q    <= '0;
         br_q    <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= win_done;
         last_q  <= win_done && frame_end;
         if (win_done) begin
            tl_q <= rd_left;
            tr_q <= rd_right;
            bl_q <= prev_px;
            br_q <= bus.in_data;
         end
      end
   end

   // The final pixel clears busy even if the next frame starts right away;
   // that next pixel raises it again one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= 1'b0;
      else if (accept) busy_q <= !frame_end;
   end

   assign bus.win_tl    = tl_q;
   assign bus.win_tr    = tr_q;
   assign bus.win_bl    = bl_q;
   assign bus.win_br    = br_q;
   assign bus.win_valid = valid_q;
   assign bus.win_last  = last_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pool_window_gather.sv
// Self-checking bench for pool_window_gather: 4x4 and 6x4 instances.
module tb_pool_window_gather;

  localparam int DW = 22;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int W2 = 6;
  localparam int H2 = 4;

  typedef struct {
    logic [DW-1:0] tl, tr, bl, br;
    bit            last;
  } win_t;

  typedef struct {
    logic [DW-1:0] px[4];
    logic [DW-1:0] exp_w[4];
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_window_gather_if #(.DATA_W(DW)) bus_a ();
  pool_window_gather_if #(.DATA_W(DW)) bus_b ();

  pool_window_gather #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pool_window_gather #(.DATA_W(DW), .IMG_W(W2), .IMG_H(H2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state for dut_a: the frame as a flat array of pixels
  logic [DW-1:0] img[W*H];
  int   pos;
  bit   exp_pulse;
  bit   exp_busy;
  win_t exp_win;
  win_t held;
  win_t got_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    exp_busy = 1'b0;
    exp_pulse = 1'b0;
    held = '{tl: '0, tr: '0, bl: '0, br: '0, last: 1'b0};
  endtask

  // Drive one cycle on dut_a, advance the model, check everything at negedge.
  task automatic step(input bit v, input logic [DW-1:0] d);
    bus_a.in_valid = v;
    bus_a.in_data  = d;
    exp_pulse = 1'b0;
    if (v) begin
      int r, c;
      img[pos] = d;
      r = pos / W;
      c = pos % W;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        exp_win = '{tl: img[pos-W-1], tr: img[pos-W], bl: img[pos-1], br: d,
                    last: (pos == W*H-1)};
        exp_pulse = 1'b1;
        held = exp_win;
      end
      exp_busy = (pos != W*H-1);
      pos = (pos + 1) % (W*H);
    end
    @(posedge clk);
    @(negedge clk);
    chk("win_valid", DW'(bus_a.win_valid), DW'(exp_pulse));
    chk("win_last", DW'(bus_a.win_last), DW'(exp_pulse && held.last));
    chk("busy", DW'(bus_a.busy), DW'(exp_busy));
    chk("win_tl", bus_a.win_tl, held.tl);
    chk("win_tr", bus_a.win_tr, held.tr);
    chk("win_bl", bus_a.win_bl, held.bl);
    chk("win_br", bus_a.win_br, held.br);
    if (bus_a.win_valid)
      got_q.push_back('{tl: bus_a.win_tl, tr: bus_a.win_tr, bl: bus_a.win_bl,
                        br: bus_a.win_br, last: bus_a.win_last});
  endtask

  // Compare captured windows of a frame whose pixel p carries base+p.
  task automatic check_seq_frame(input int base, input int first);
    for (int k = 0; k < (W/2)*(H/2); k++) begin
      int tl;
      tl = base + (2*(k / (W/2)))*W + 2*(k % (W/2));
      if (got_q.size() <= first + k) begin
        chk("window_count", DW'(got_q.size()), DW'(first + k + 1));
        return;
      end
      chk("seq_tl", got_q[first+k].tl, DW'(tl));
      chk("seq_tr", got_q[first+k].tr, DW'(tl + 1));
      chk("seq_bl", got_q[first+k].bl, DW'(tl + W));
      chk("seq_br", got_q[first+k].br, DW'(tl + W + 1));
      chk("seq_last", DW'(got_q[first+k].last), DW'(k == (W/2)*(H/2)-1));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    #1;
    chk("rst_valid", DW'(bus_a.win_valid), '0);
    chk("rst_tl", bus_a.win_tl, '0);
    chk("rst_br", bus_a.win_br, '0);
    chk("rst_busy", DW'(bus_a.busy), '0);
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", DW'(bus_a.win_valid), '0);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[3];
  int   q_b_pix[$];
  win_t q_b[$];

  initial begin
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = '0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = '0;

    tbl[0].px = '{22'h3FFFFF, 22'h200000, 22'h000001, 22'h1FFFFF};
    tbl[0].exp_w = '{22'h3FFFFF, 22'h200000, 22'h000001, 22'h1FFFFF};
    tbl[1].px = '{22'h000000, 22'h3FFFFF, 22'h1FFFFF, 22'h200000};
    tbl[1].exp_w = '{22'h000000, 22'h3FFFFF, 22'h1FFFFF, 22'h200000};
    tbl[2].px = '{22'h2AAAAA, 22'h155555, 22'h3FFFFE, 22'h000002};
    tbl[2].exp_w = '{22'h2AAAAA, 22'h155555, 22'h3FFFFE, 22'h000002};

    // reset state
    @(negedge clk);
    do_reset();
    step(1'b0, '0);

    // consecutive 0..15
    got_q.delete();
    for (int p = 0; p < W*H; p++) step(1'b1, DW'(p));
    step(1'b0, '0);
    chk("frame1_count", DW'(got_q.size()), DW'(4));
    check_seq_frame(0, 0);

    // same frame with a gap every other cycle
    got_q.delete();
    for (int p = 0; p < W*H; p++) begin
      step(1'b1, DW'(p));
      step(1'b0, DW'($urandom));
    end
    chk("gap_count", DW'(got_q.size()), DW'(4));
    check_seq_frame(0, 0);

    // signed pass-through table: window 0 built from each vector
    for (int i = 0; i < 3; i++) begin
      got_q.delete();
      for (int p = 0; p < W*H; p++) begin
        logic [DW-1:0] d;
        d = DW'($urandom);
        if (p == 0) d = tbl[i].px[0];
        if (p == 1) d = tbl[i].px[1];
        if (p == W) d = tbl[i].px[2];
        if (p == W+1) d = tbl[i].px[3];
        step(1'b1, d);
      end
      step(1'b0, '0);
      if (got_q.size() == 0) begin
        chk("tbl_count", '0, DW'(4));
      end else begin
        chk("tbl_tl", got_q[0].tl, tbl[i].exp_w[0]);
        chk("tbl_tr", got_q[0].tr, tbl[i].exp_w[1]);
        chk("tbl_bl", got_q[0].bl, tbl[i].exp_w[2]);
        chk("tbl_br", got_q[0].br, tbl[i].exp_w[3]);
      end
    end

    // two frames back to back
    got_q.delete();
    for (int p = 0; p < 2*W*H; p++) step(1'b1, DW'(p < W*H ? p : 100 + p - W*H));
    step(1'b0, '0);
    chk("b2b_count", DW'(got_q.size()), DW'(8));
    check_seq_frame(0, 0);
    check_seq_frame(100, 4);

    // reset after pixel 6, then a full frame 100..115
    for (int p = 0; p <= 6; p++) step(1'b1, DW'(p));
    do_reset();
    step(1'b0, '0);
    got_q.delete();
    for (int p = 0; p < W*H; p++) step(1'b1, DW'(100 + p));
    step(1'b0, '0);
    chk("post_rst_count", DW'(got_q.size()), DW'(4));
    check_seq_frame(100, 0);

    // randomized frames with random gaps against the model
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < W*H; p++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, DW'($urandom));
        step(1'b1, DW'($urandom));
      end
    end
    step(1'b0, '0);

    // 6x4 instance, pixels 0..23
    for (int p = 0; p < W2*H2; p++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = DW'(p);
      @(posedge clk);
      @(negedge clk);
      if (bus_b.win_valid) begin
        q_b_pix.push_back(p);
        q_b.push_back('{tl: bus_b.win_tl, tr: bus_b.win_tr, bl: bus_b.win_bl,
                        br: bus_b.win_br, last: bus_b.win_last});
      end
    end
    bus_b.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b_extra_valid", DW'(bus_b.win_valid), '0);
    chk("b_busy_end", DW'(bus_b.busy), '0);
    chk("b_count", DW'(q_b.size()), DW'(6));
    for (int k = 0; k < 6 && k < q_b.size(); k++) begin
      int tl;
      tl = (2*(k / 3))*W2 + 2*(k % 3);
      chk("b_tl", q_b[k].tl, DW'(tl));
      chk("b_tr", q_b[k].tr, DW'(tl + 1));
      chk("b_bl", q_b[k].bl, DW'(tl + W2));
      chk("b_br", q_b[k].br, DW'(tl + W2 + 1));
      chk("b_last", DW'(q_b[k].last), DW'(k == 5));
      chk("b_latency", DW'(q_b_pix[k]), DW'(tl + W2 + 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_window_gather.md
Name: pool_window_gather

Overview:
- Upstream neighbour of the max-pooling stage. Takes the convolution layer's output feature map as a raster-order stream of signed 22-bit pixels, one per qualified cycle.
- Reassembles each non-overlapping 2x2 window (stride 2) and presents its four pixels in parallel with a one-cycle valid strobe, which drives the pooling stage's enable.
- Holds one feature-map row in a line buffer so no frame memory is needed.

Parameters:
- DATA_W, 22, pixel width (two's-complement fixed point, passed through untouched).
- IMG_W, 4, feature-map width in pixels; even, >=2.
- IMG_H, 4, feature-map height in pixels; even, >=2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data carries a pixel this cycle.
- in_data  in  DATA_W  pixel, raster order (row 0 col 0 first).
- win_tl  out  DATA_W  window top-left; connects to pooling input1.
- win_tr  out  DATA_W  window top-right; connects to input2.
- win_bl  out  DATA_W  window bottom-left; connects to input3.
- win_br  out  DATA_W  window bottom-right; connects to input4.
- win_valid  out  1  one-cycle strobe, window outputs valid; connects to pooling enable.
- win_last  out  1  high with win_valid for the final window of a frame.
- busy  out  1  high from the first accepted pixel of a frame until the cycle win_last is issued.

Behaviour:
- Reset (async assert, sync release): col=0, row=0, every output 0. Line-buffer contents are don't-care and need not be reset.
- No backpressure. Every cycle with in_valid=1 consumes exactly one pixel. Cycles with in_valid=0 are gaps and change no state, except that win_valid/win_last fall.
- Counters:
  - col increments per accepted pixel and wraps IMG_W-1 -> 0.
  - On a col wrap, row increments and wraps IMG_H-1 -> 0.
  - After the last pixel of a frame, the next pixel is row 0 col 0 of a new frame; back-to-back frames need no idle cycle.
- Even row (row[0]=0): pixel written to line_buf[col].
- Odd row, even col: pixel held in register prev_px.
- Odd row, odd col: window complete. On the next rising edge:
  - win_tl=line_buf[col-1], win_tr=line_buf[col], win_bl=prev_px, win_br=in_data.
  - win_valid=1.
  - win_last=1 iff row==IMG_H-1 and col==IMG_W-1.
- Latency: window outputs register one cycle after the bottom-right pixel is accepted.
- Window outputs hold their last values when win_valid=0. win_valid and win_last are single-cycle pulses, even with consecutive in_valid.
- Windows per frame: (IMG_W/2)*(IMG_H/2), emitted in raster order of windows.
- busy: set on any accepted pixel, cleared on the cycle win_last is registered. A simultaneous new pixel re-sets it on the following cycle (clear has priority for that one cycle).
- Line-buffer reads for row r+1 always complete before the same addresses are overwritten by row r+2, so no read/write collision is possible.
- Reset mid-frame: partial frame discarded; the next accepted pixel is treated as row 0 col 0. No spurious win_valid.
- Counter widths: $clog2 of IMG_W and IMG_H, minimum 1 bit.
- Elaboration-time check: IMG_W and IMG_H must be even and >=2, else $error.

Decomposition:
- Shared package cnn_pkg: DATA_W default constant and pixel typedef, so this block, maxPooling and the convolution stage share one width.
- One sub-module, pool_line_buffer: IMG_W x DATA_W, 1 write port, 2 registered-address-free read ports (col-1, col); synthesis may infer distributed RAM.
- Counters and window registers stay in the top module.

Test Plan:
- 4x4 frame, in_data=0..15 on consecutive cycles -> windows (tl,tr,bl,br) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15). Each win_valid is one cycle after pixels 5, 7, 13, 15. win_last only on the fourth window.
- Same frame with in_valid deasserted every other cycle -> identical window values and order; win_valid pulses stay one cycle wide; outputs hold between pulses.
- Signed pass-through: pixels 22'h3FFFFF, 22'h200000, 22'h000001, 22'h1FFFFF as window 0 -> outputs bit-exact, no sign or width alteration.
- Two 4x4 frames back-to-back with no gap -> 8 windows; win_last after windows 4 and 8; busy stays high across the boundary except the single clear cycle.
- Reset asserted after pixel 6 of a frame, then a full frame 100..115 -> first window (100,101,104,105); no win_valid during or right after reset.
- IMG_W=6, IMG_H=4, pixels 0..23 -> six windows, first (0,1,6,7), last (16,17,22,23) with win_last.
